pwm_fader: RTL
==============

Name: pwm_fader

Overview:
- Upstream duty-value generator for the 8-bit PWM stage.
- Accepts a target duty via a valid/ready handshake, then ramps value_out toward it by a programmable step.
- Updates happen only at PWM period boundaries, signalled by the PWM core's sync strobe. value_out drives the PWM wrapper's value_in directly.
- Typical use: LED brightness fades without glitches or mid-period duty changes.

Parameters:
- WIDTH, 8: duty width for value_out, tgt_value and step. Must match the PWM core.
- DIV_W, 8: width of the period-divider setting div.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- sync  in  1  period-start strobe from the PWM core (high while its counter is 0)
- tgt_value  in  WIDTH  requested final duty
- tgt_valid  in  1  target request
- tgt_ready  out  1  target accepted when tgt_valid & tgt_ready
- step  in  WIDTH  duty change per ramp tick; sampled at accept
- div  in  DIV_W  ramp tick every div+1 period starts; sampled at accept
- value_out  out  WIDTH  current duty, registered
- busy  out  1  ramp in progress
- done  out  1  one-cycle pulse when the target is reached

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk.
  - Reset values: value_out=0, busy=0, done=0, tgt_ready=1, latched target/step/div=0, divider count=0, sync_q=0, state=IDLE.
  - Reset mid-ramp aborts immediately; value_out returns to 0.
- Period edge: pedge = sync & ~sync_q, with sync_q registered.
  - sync held high for N cycles counts as one edge.
  - sync stuck low means no ticks; the ramp stalls and busy stays high.
- Divider count:
  - Cleared on accept.
  - Increments on each pedge.
  - tick = pedge & (count == latched div); the count clears on tick.
  - div=0 gives a tick on every period start.
- FSM states: IDLE, UP, DOWN.
  - tgt_ready = (state == IDLE).
  - Accept in IDLE latches tgt_value, div, and step (step 0 is stored as 1).
  - After accept: target > value_out goes to UP; target < value_out goes to DOWN.
  - target == value_out stays in IDLE and pulses done in the next cycle.
  - busy = (state != IDLE), registered with the state.
- UP on tick: value_out <= min(value_out + step, target), computed WIDTH+1 bits wide (no wrap past 255).
- DOWN on tick: value_out <= max(value_out - step, target), with borrow checked (no wrap below 0).
- Reaching target: when the new value equals target, go to IDLE. done pulses for exactly 1 cycle, coincident with busy falling.
- Latency and timing:
  - value_out changes on the clk edge that registers the tick, i.e. the edge ending the sync-high cycle.
  - The PWM wrapper therefore applies the new value from the following period.
  - value_out is otherwise constant across whole periods.
- Ramp duration: ceil(|target - start| / step) ticks, each of (div+1) period starts.
- tgt_valid while busy: ignored. The request is held by the requester until ready.
- step/div changes while busy: no effect; the latched copies are used.

Optional Feature:
- Macro: PWM_FADER_BREATHE_EN.
- Defined:
  - Adds input port breathe (1 bit), sampled at accept and continuously thereafter.
  - With breathe high, reaching target in UP turns to DOWN toward 0, and reaching 0 turns to UP toward target.
  - Loops indefinitely and busy stays high; done does not pulse at turnarounds.
  - Deasserting breathe lets the current leg finish, then the block goes to IDLE and pulses done.
  - A leg toward 0 ends with value_out=0.
- Undefined: the port is absent and the behaviour is exactly as above.

Decomposition:
- Package pwm_fader_pkg:
  - state typedef: 2-bit, IDLE=0, UP=1, DOWN=2.
  - Default WIDTH=8 and DIV_W=8 constants.
- Sub-module pwm_tick_div:
  - Contains the sync edge detector plus the period divider.
  - Inputs: clk, rst, sync, clear, div. Output: tick.

Test Plan:
- Reset check: after reset, value_out=0, busy=0, tgt_ready=1, done=0. Assert rst mid-ramp at value 60 -> value_out=0 and busy=0 in the same cycle.
- Ramp up: from 0, target=100, step=30, div=0 -> value_out 30, 60, 90, 100 on 4 consecutive sync edges. One done pulse with the 100 update; busy then low.
- Clamped ramp down: from 100, target=10, step=200, div=1 -> value_out stays 100 through the 1st sync edge, becomes 10 at the 2nd. No underflow; done pulses.
- Edge cases:
  - step=0, div=3, 5->7: +1 every 4 sync edges.
  - tgt_valid with tgt_value=200 while busy -> tgt_ready=0 and ignored.
  - sync held high for 10 cycles -> one tick.
  - target 255, step 255 from 0 -> 255 with no wrap.
- Equal target and breathe: tgt_value == value_out=42 -> busy never rises; done pulses 1 cycle after accept. With PWM_FADER_BREATHE_EN, breathe=1, target=50, step=25 -> value_out 25, 50, 25, 0, 25 and so on. Drop breathe during the down leg -> ends at 0 and done pulses.

Source files
------------

// File: rtl/pwm_fader_pkg.sv
// Shared definitions for the pwm_fader duty ramp generator.
// State encoding is kept as plain 2-bit constants so existing code that
// compares raw state values keeps working.
package pwm_fader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t UP   = 2'd1;
    localparam state_t DOWN = 2'd2;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIV_W = 8;

endpackage

// File: rtl/pwm_tick_div.sv
// Period-start edge detector plus period divider.
// Produces a one-cycle tick on every (div+1)-th rising edge of sync.
// The tick is combinational so the owner can act on the edge that ends
// the first sync-high cycle.
module pwm_tick_div
    import pwm_fader_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic             sync_q;
    logic [DIV_W-1:0] count;
    logic             pedge;

    // A long sync-high stretch yields exactly one edge.
    assign pedge = sync & ~sync_q;
    assign tick  = pedge & (count == div);

    // Delayed copy of sync for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 1'b0;
        else     sync_q <= sync;
    end

    // Period counter: restarts on a new request and after every tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        count <= '0;
        else if (clear) count <= '0;
        else if (tick)  count <= '0;
        else if (pedge) count <= count + 1'b1;
    end

endmodule

// File: rtl/pwm_fader.sv
// Duty ramp generator feeding the 8-bit PWM wrapper.
// A target is accepted over a valid/ready handshake, then value_out walks
// toward it by the latched step once per divided PWM period.
// Optional macro PWM_FADER_BREATHE_EN adds the breathe input, which makes
// the ramp bounce between the target and 0 until it is released.
module pwm_fader
    import pwm_fader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic [WIDTH-1:0] tgt_value,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] step,
    input  logic [DIV_W-1:0] div,
`ifdef PWM_FADER_BREATHE_EN
    input  logic             breathe,
`endif
    output logic [WIDTH-1:0] value_out,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [WIDTH-1:0] tgt_lat, tgt_n;
    logic [WIDTH-1:0] step_lat, step_n;
    logic [DIV_W-1:0] div_lat, div_n;
    logic [WIDTH-1:0] value_n;
    logic             done_n;
    logic             zero_leg, zero_leg_n;
    logic             accept;
    logic             tick;
    logic             breathe_on;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] leg_tgt;

`ifdef PWM_FADER_BREATHE_EN
    assign breathe_on = breathe;
`else
    assign breathe_on = 1'b0;
`endif

    assign tgt_ready = (state == IDLE);
    assign accept    = tgt_valid & tgt_ready;

    // One extra bit so overshoot above full scale and borrow below 0 are visible.
    assign sum     = {1'b0, value_out} + {1'b0, step_lat};
    assign diff    = {1'b0, value_out} - {1'b0, step_lat};
    // A breathe down-leg heads for 0 instead of the requested target.
    assign leg_tgt = zero_leg ? '0 : tgt_lat;

    pwm_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk   (clk),
        .rst   (rst),
        .sync  (sync),
        .clear (accept),
        .div   (div_lat),
        .tick  (tick)
    );

    // Next-state and next-duty selection.
    always_comb begin
        state_n    = state;
        value_n    = value_out;
        done_n     = 1'b0;
        zero_leg_n = zero_leg;
        tgt_n      = tgt_lat;
        step_n     = step_lat;
        div_n      = div_lat;
        case (state)
            IDLE: begin
                if (accept) begin
                    tgt_n      = tgt_value;
                    div_n      = div;
                    step_n     = (step == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : step;
                    zero_leg_n = 1'b0;
                    if (tgt_value > value_out)      state_n = UP;
                    else if (tgt_value < value_out) state_n = DOWN;
                    else                            done_n  = 1'b1;
                end
            end
            UP: begin
                if (tick) begin
                    if (sum >= {1'b0, tgt_lat}) begin
                        value_n = tgt_lat;
                        if (breathe_on) begin
                            state_n    = DOWN;
                            zero_leg_n = 1'b1;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        value_n = sum[WIDTH-1:0];
                    end
                end
            end
            DOWN: begin
                if (tick) begin
                    if (diff[WIDTH] || (diff[WIDTH-1:0] <= leg_tgt)) begin
                        value_n = leg_tgt;
                        if (breathe_on && zero_leg) begin
                            state_n    = UP;
                            zero_leg_n = 1'b0;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        value_n = diff[WIDTH-1:0];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Register state, duty and status; busy and done move on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            value_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            zero_leg  <= 1'b0;
            tgt_lat   <= '0;
            step_lat  <= '0;
            div_lat   <= '0;
        end else begin
            state     <= state_n;
            value_out <= value_n;
            busy      <= (state_n != IDLE);
            done      <= done_n;
            zero_leg  <= zero_leg_n;
            tgt_lat   <= tgt_n;
            step_lat  <= step_n;
            div_lat   <= div_n;
        end
    end

endmodule
